// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller.
package hazard_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } hz_state_e;

   localparam int MUL_LAT_DEF = 3;
   localparam int K_W         = 4;

endpackage : hazard_pkg

// File: rtl/mul_latency_counter.sv
// Tracks how long a multiply has occupied EX and flags its busy/final cycles.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// IDLE     | no multiply in progress; a multiply seen here is at k=0
// MUL_BUSY | multiply in EX for k>=1 cycles; final cycle when k==MUL_LAT-1
module mul_latency_counter
   import hazard_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic clk,
   input  logic arst_n,
   input  logic mul_ID_EX,
   output logic mul_busy,
   output logic mul_done
);

   localparam logic [K_W-1:0] K_LAST = K_W'(MUL_LAT - 1);

   hz_state_e      state_q, state_d;
   logic [K_W-1:0] k_q, k_d;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      mul_busy = 1'b0;
      mul_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mul_ID_EX) begin
               if (MUL_LAT > 1) begin
                  mul_busy = 1'b1;
                  state_d  = MUL_BUSY;
                  k_d      = K_W'(1);
               end else begin
                  mul_done = 1'b1;
               end
            end
         end
         MUL_BUSY: begin
            if (k_q < K_LAST) begin
               mul_busy = 1'b1;
               k_d      = k_q + K_W'(1);
            end else begin
               mul_done = 1'b1;
               state_d  = IDLE;
               k_d      = '0;
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
         end
      endcase
   end

endmodule : mul_latency_counter

// File: rtl/hazard_stall_unit.sv
// Load-use and multiply stall control for the ID stage.
// HAZARD_PERF_CNT_EN enables the saturating stall_cycles counter; otherwise it reads 0.
module hazard_stall_unit
   import hazard_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [REG_W-1:0] rs1_IF_ID,
   input  logic [REG_W-1:0] rs2_IF_ID,
   input  logic             uses_rs2_IF_ID,
   input  logic [REG_W-1:0] rd_ID_EX,
   input  logic             mem_read_ID_EX,
   input  logic             mul_ID_EX,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_bubble,
   output logic             mul_busy,
   output logic             mul_done,
   output logic [CNT_W-1:0] stall_cycles
);

   logic mc_busy, mc_done;
   logic lu;

   mul_latency_counter #(
      .MUL_LAT (MUL_LAT)
   ) u_mul_cnt (
      .clk       (clk),
      .arst_n    (arst_n),
      .mul_ID_EX (mul_ID_EX),
      .mul_busy  (mc_busy),
      .mul_done  (mc_done)
   );

   // A load and a multiply never share EX, so a multiply flag wins over mem_read.
   assign lu = mem_read_ID_EX && !mul_ID_EX && (rd_ID_EX != '0) &&
               ((rd_ID_EX == rs1_IF_ID) ||
                (uses_rs2_IF_ID && (rd_ID_EX == rs2_IF_ID)));

   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      mul_busy      = 1'b0;
      mul_done      = 1'b0;
      // Outputs go non-stall the moment reset asserts, without waiting for a clock.
      if (arst_n) begin
         mul_busy = mc_busy;
         mul_done = mc_done;
         if (mc_busy) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
         end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_q <= '0;
      end else if (!pc_write && (stall_q != '1)) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule : hazard_stall_unit
